sample_reader: RTL and testbench

Reads a captured frame out of the sample memory once the capture side has finished writing it. Starts at the oldest sample's address and walks the whole circular buffer in order, wrapping at the top. Emits a marker byte, then every sample, on a valid/ready byte stream toward the host link. Sits between the sample memory read port and the host transmit path.

---
 rtl/oscilo_pkg.sv | 16 +
 rtl/sample_reader.sv | 114 +++++++++++
 tb/tb_sample_reader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/oscilo_pkg.sv
// rtl/oscilo_pkg.sv - shared constants and types for the sample readout path
package oscilo_pkg;

    localparam int          DEFAULT_SAMPLE_DEPTH = 8;
    localparam logic [7:0]  DEFAULT_FRAME_MARKER = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } reader_state_t;

endpackage

// File: rtl/sample_reader.sv
// rtl/sample_reader.sv - streams a captured circular frame out of sample memory
//
// Ports:
//   clk_50mhz               system clock, rising edge
//   reset                   asynchronous active-low reset
//   start, start_addr       readout request and oldest-sample address (IDLE only)
//   busy, done              non-IDLE indicator, one-cycle end-of-frame pulse
//   mem_re, mem_addr        sample memory read port (data returns next cycle)
//   mem_rdata               sample memory read data
//   tx_data, tx_valid       byte stream toward the host link
//   tx_ready                sink accept
module sample_reader
    import oscilo_pkg::*;
#(
    parameter int         SAMPLE_DEPTH = DEFAULT_SAMPLE_DEPTH,
    parameter logic [7:0] FRAME_MARKER = DEFAULT_FRAME_MARKER
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SAMPLE_DEPTH-1:0] start_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_re,
    output logic [SAMPLE_DEPTH-1:0] mem_addr,
    input  logic [7:0]              mem_rdata,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
);

    // Count carries one extra bit so the full-frame value 2^SAMPLE_DEPTH fits.
    localparam logic [SAMPLE_DEPTH:0] COUNT_ONE  = {{SAMPLE_DEPTH{1'b0}}, 1'b1};
    localparam logic [SAMPLE_DEPTH:0] COUNT_FULL = {1'b1, {SAMPLE_DEPTH{1'b0}}};

    reader_state_t           state;
    logic [SAMPLE_DEPTH-1:0] base;
    logic [SAMPLE_DEPTH:0]   count;
    logic [SAMPLE_DEPTH:0]   next_count;
    logic [SAMPLE_DEPTH-1:0] next_addr;

    // mem_re/mem_addr are registered, so they are loaded on the edge that
    // enters FETCH; the address for the next sample is therefore computed
    // from the incremented count. Truncation gives the circular wrap.
    assign next_count = count + COUNT_ONE;
    assign next_addr  = base + next_count[SAMPLE_DEPTH-1:0];

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            base     <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_re   <= 1'b0;
            mem_addr <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base     <= start_addr;
                        count    <= '0;
                        tx_data  <= FRAME_MARKER;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        mem_re   <= 1'b1;
                        mem_addr <= base;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    mem_re <= 1'b0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    tx_data  <= mem_rdata;
                    tx_valid <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        count    <= next_count;
                        if (next_count == COUNT_FULL) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            mem_re   <= 1'b1;
                            mem_addr <= next_addr;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_reader.sv
// tb/tb_sample_reader.sv - scoreboard bench for sample_reader
module tb_sample_reader;

    logic       clk_50mhz = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic       busy, done, mem_re, tx_valid;
    logic [7:0] mem_addr, tx_data;
    logic [7:0] mem_rdata = 8'h00;
    logic       tx_ready = 1'b0;

    sample_reader dut (
        .clk_50mhz  (clk_50mhz),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .busy       (busy),
        .done       (done),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int cyc = 0;
    always @(posedge clk_50mhz) cyc <= cyc + 1;

    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    always @(posedge clk_50mhz) if (mem_re) mem_rdata <= mem[mem_addr];

    logic [7:0] exp_q[$];
    logic [7:0] addr_q[$];
    int tests = 0, fails = 0;
    int rx_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic       stalled = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: everything sampled mid-cycle, tx_ready only changes just after posedge.
    always @(negedge clk_50mhz) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stalled) begin
            check("stall_valid", tx_valid, 1);
            check("stall_data", tx_data, stall_data);
        end
        if (mem_re) begin
            if (addr_q.size() == 0) check("extra_read", 1, 0);
            else check("mem_addr", mem_addr, addr_q.pop_front());
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("extra_byte", 1, 0);
            else check("tx_data", tx_data, exp_q.pop_front());
            rx_cnt++;
        end
        stalled    = tx_valid && !tx_ready;
        stall_data = tx_data;
    end

    // Ready driver: mode 0 always ready; mode 1 ~30% duty plus one 50-cycle stall after byte 10.
    int ready_mode = 0;
    int stall_left = 0;
    bit stalled_once = 1'b0;
    always @(posedge clk_50mhz) begin
        #1;
        if (ready_mode == 0) begin
            tx_ready = 1'b1;
        end else if (stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
        end else if (rx_cnt == 11 && !stalled_once) begin
            stalled_once = 1'b1;
            stall_left   = 49;
            tx_ready     = 1'b0;
        end else begin
            tx_ready = ($urandom_range(0, 99) < 30);
        end
    end

    task automatic start_frame(input logic [7:0] a, output int e);
        logic [7:0] v;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 256; i++) begin
            v = a + 8'(i);
            exp_q.push_back(v);
            addr_q.push_back(v);
        end
        rx_cnt = 0;
        @(posedge clk_50mhz);
        #2;
        start_addr = a;
        start      = 1'b1;
        @(posedge clk_50mhz);
        #2;
        e     = cyc;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("marker_valid", tx_valid, 1);
        check("marker_data", tx_data, 8'hA5);
    endtask

    task automatic wait_done(input int budget, input int d0);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk_50mhz);
            if (done_cnt > d0) break;
        end
        check("done_seen", done_cnt > d0, 1);
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk_50mhz);
            if (rx_cnt >= n) break;
        end
        check("rx_progress", rx_cnt >= n, 1);
    endtask

    task automatic finish_frame(input int d0);
        repeat (5) @(posedge clk_50mhz);
        #2;
        check("byte_count", rx_cnt, 257);
        check("exp_left", exp_q.size(), 0);
        check("addr_left", addr_q.size(), 0);
        check("done_once", done_cnt - d0, 1);
        check("busy_idle", busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mem_re"}, mem_re, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, d0;
        repeat (3) @(posedge clk_50mhz);
        #2;
        check_reset_vals("por");
        reset = 1'b1;
        repeat (2) @(posedge clk_50mhz);

        // Frame from address 0 with full-rate sink, including exact latency.
        d0 = done_cnt;
        start_frame(8'h00, e);
        wait_done(3000, d0);
        check("done_cycle", done_cyc, e + 769);
        @(negedge clk_50mhz);
        check("busy_low_e770", busy, 0);
        check("done_low_e770", done, 0);
        finish_frame(d0);

        // Mid-buffer start and top-of-buffer wrap.
        d0 = done_cnt;
        start_frame(8'h80, e);
        wait_done(3000, d0);
        finish_frame(d0);

        d0 = done_cnt;
        start_frame(8'hFF, e);
        wait_done(3000, d0);
        finish_frame(d0);

        // Random backpressure with a long stall.
        ready_mode   = 1;
        stalled_once = 1'b0;
        d0 = done_cnt;
        start_frame(8'h00, e);
        wait_done(10000, d0);
        ready_mode = 0;
        finish_frame(d0);

        // start / start_addr disturbance while busy.
        d0 = done_cnt;
        start_frame(8'h00, e);
        wait_rx(50, 1000);
        @(posedge clk_50mhz);
        #2;
        start_addr = 8'h40;
        start      = 1'b1;
        @(posedge clk_50mhz);
        #2;
        start = 1'b0;
        wait_done(3000, d0);
        finish_frame(d0);

        // Reset mid-frame, then a fresh frame.
        d0 = done_cnt;
        start_frame(8'h00, e);
        wait_rx(101, 1000);
        @(negedge clk_50mhz);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(posedge clk_50mhz);
        #2;
        check_reset_vals("held_rst");
        reset = 1'b1;
        repeat (5) @(posedge clk_50mhz);
        check("no_done_abort", done_cnt, d0);

        d0 = done_cnt;
        start_frame(8'h10, e);
        wait_done(3000, d0);
        finish_frame(d0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
